// File: rtl/care_ctrl.sv
// rtl/care_ctrl.sv - care action controller: menu selection, paced decrement pulses, cooldown
module care_ctrl #(
    parameter int AMOUNT    = 4,
    parameter int PULSE_GAP = 2,
    parameter int COOLDOWN  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        btn_ok,
    input  logic        btn_cancel,
    input  logic [23:0] stat_levels,
    output logic [7:0]  care_pulse,
    output logic [2:0]  menu_sel,
    output logic        busy,
    output logic [3:0]  last_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_COOLDOWN
    } state_t;

    localparam logic [3:0]  AMOUNT_W = 4'(AMOUNT);
    localparam logic [7:0]  GAP_W    = 8'(PULSE_GAP);
    localparam logic [19:0] CD_LOAD  = 20'(COOLDOWN - 1);

    state_t      state, state_d;
    logic [2:0]  menu_sel_d;
    logic [2:0]  target, target_d;
    logic [3:0]  pulse_cnt, pulse_cnt_d;
    logic [7:0]  gap_cnt, gap_cnt_d;
    logic [19:0] cd_cnt, cd_cnt_d;
    logic [3:0]  last_count_d;
    logic [7:0]  care_pulse_d;
    logic        busy_d;
    logic        prev_next, prev_ok, prev_cancel;
    logic        next_press, ok_press, cancel_press;
    logic [4:0]  lvl_idx;
    logic [3:0]  sel_level;

    // History registers reset high so a button held through reset is not a press
    assign next_press   = btn_next   & ~prev_next;
    assign ok_press     = btn_ok     & ~prev_ok;
    assign cancel_press = btn_cancel & ~prev_cancel;

    assign lvl_idx   = {target, 2'b00};
    assign sel_level = stat_levels[lvl_idx +: 4];

    always_comb begin
        state_d      = state;
        menu_sel_d   = menu_sel;
        target_d     = target;
        pulse_cnt_d  = pulse_cnt;
        gap_cnt_d    = gap_cnt;
        cd_cnt_d     = cd_cnt;
        last_count_d = last_count;
        care_pulse_d = 8'b0;
        case (state)
            S_IDLE: begin
                if (ok_press) begin
                    state_d     = S_APPLY;
                    target_d    = menu_sel;
                    pulse_cnt_d = 4'd0;
                    gap_cnt_d   = 8'd0;
                end else if (next_press) begin
                    menu_sel_d = (menu_sel == 3'd5) ? 3'd0 : menu_sel + 3'd1;
                end
            end
            S_APPLY: begin
                if (cancel_press) begin
                    state_d      = S_COOLDOWN;
                    cd_cnt_d     = CD_LOAD;
                    last_count_d = pulse_cnt;
                end else if (gap_cnt == 8'd0) begin
                    if (pulse_cnt == AMOUNT_W || sel_level == 4'd0) begin
                        state_d      = S_COOLDOWN;
                        cd_cnt_d     = CD_LOAD;
                        last_count_d = pulse_cnt;
                    end else begin
                        care_pulse_d = 8'b1 << target;
                        pulse_cnt_d  = pulse_cnt + 4'd1;
                        gap_cnt_d    = GAP_W;
                    end
                end else begin
                    gap_cnt_d = gap_cnt - 8'd1;
                end
            end
            S_COOLDOWN: begin
                if (cd_cnt == 20'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cd_cnt_d = cd_cnt - 20'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            menu_sel    <= 3'd0;
            target      <= 3'd0;
            pulse_cnt   <= 4'd0;
            gap_cnt     <= 8'd0;
            cd_cnt      <= 20'd0;
            last_count  <= 4'd0;
            care_pulse  <= 8'b0;
            busy        <= 1'b0;
            prev_next   <= 1'b1;
            prev_ok     <= 1'b1;
            prev_cancel <= 1'b1;
        end else begin
            state       <= state_d;
            menu_sel    <= menu_sel_d;
            target      <= target_d;
            pulse_cnt   <= pulse_cnt_d;
            gap_cnt     <= gap_cnt_d;
            cd_cnt      <= cd_cnt_d;
            last_count  <= last_count_d;
            care_pulse  <= care_pulse_d;
            busy        <= busy_d;
            prev_next   <= btn_next;
            prev_ok     <= btn_ok;
            prev_cancel <= btn_cancel;
        end
    end

endmodule

// File: tb/tb_care_ctrl.sv
// tb/tb_care_ctrl.sv - directed self-checking bench for care_ctrl
module tb_care_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_next, btn_ok, btn_cancel;
    logic [23:0] stat_levels;
    logic [7:0]  care_pulse;
    logic [2:0]  menu_sel;
    logic        busy;
    logic [3:0]  last_count;

    logic [23:0] stat_init;
    logic        dec_clr;
    logic [3:0]  dec [6];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int npulse = 0;
    int pcnt [8];
    int pt [64];
    int busy_cnt = 0;
    int bad = 0;

    care_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .btn_next   (btn_next),
        .btn_ok     (btn_ok),
        .btn_cancel (btn_cancel),
        .stat_levels(stat_levels),
        .care_pulse (care_pulse),
        .menu_sel   (menu_sel),
        .busy       (busy),
        .last_count (last_count)
    );

    always #5 clk = ~clk;

    // Stats model: each pulse decrements its stat, saturating at zero
    always_comb begin
        stat_levels = '0;
        for (int k = 0; k < 6; k++) begin
            stat_levels[4*k +: 4] = stat_init[4*k +: 4] - dec[k];
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        busy_cnt += int'(busy);
        if (care_pulse[7:6] != 2'b0 || $countones(care_pulse) > 1 || (care_pulse != 8'b0 && !busy))
            bad++;
        for (int k = 0; k < 8; k++) begin
            if (care_pulse[k]) begin
                pcnt[k]++;
                pt[npulse % 64] = cyc;
                npulse++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (dec_clr)
                dec[k] = 4'd0;
            else if (care_pulse[k] && dec[k] < stat_init[4*k +: 4])
                dec[k] = dec[k] + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        dec_clr = 1'b1;
        tick(2);
        reset = 1'b0;
        dec_clr = 1'b0;
        tick(1);
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        tick(1);
        btn_next = 1'b0;
        tick(1);
    endtask

    task automatic press_ok(output int c0);
        btn_ok = 1'b1;
        tick(1);
        c0 = cyc;
        btn_ok = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, {31'b0, busy}, 0);
    endtask

    task automatic wait_pulses(input string tag, input int base, input int cnt);
        int n = 0;
        while ((npulse - base) < cnt && n < 100) begin
            tick(1);
            n++;
        end
        chk(tag, npulse - base, cnt);
    endtask

    int c0, b_np, b_busy;

    initial begin
        for (int k = 0; k < 8; k++) pcnt[k] = 0;
        for (int k = 0; k < 6; k++) dec[k] = 4'd0;
        reset = 1'b1; dec_clr = 1'b1;
        btn_next = 1'b0; btn_ok = 1'b0; btn_cancel = 1'b0;
        stat_init = 24'h999999;
        tick(3);
        chk("rst_pulse", care_pulse, 0);
        chk("rst_menu", menu_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", last_count, 0);
        reset = 1'b0; dec_clr = 1'b0;
        tick(2);

        // Menu wrap and hold-as-single-press
        for (int i = 0; i < 3; i++) press_next();
        chk("menu_3", menu_sel, 3);
        for (int i = 0; i < 3; i++) press_next();
        chk("menu_wrap", menu_sel, 0);
        btn_next = 1'b1;
        tick(50);
        btn_next = 1'b0;
        tick(2);
        chk("menu_hold", menu_sel, 1);

        // Default action on stat 2
        do_reset();
        press_next(); press_next();
        chk("t1_menu", menu_sel, 2);
        b_np = npulse; b_busy = busy_cnt;
        press_ok(c0);
        wait_idle("t1_idle", 3000);
        chk("t1_pulses", pcnt[2], 4);
        chk("t1_total", npulse - b_np, 4);
        chk("t1_first", pt[b_np % 64], c0 + 1);
        for (int i = 0; i < 3; i++)
            chk("t1_spacing", pt[(b_np + i + 1) % 64] - pt[(b_np + i) % 64], 3);
        chk("t1_last", last_count, 4);
        chk("t1_busy_cycles", busy_cnt - b_busy, 1013);
        chk("t1_menu_after", menu_sel, 2);

        // Hunger level 2 stops the action early
        stat_init = 24'h999992;
        do_reset();
        b_np = npulse;
        press_ok(c0);
        wait_idle("t2_idle", 3000);
        chk("t2_pulses", pcnt[0], 2);
        chk("t2_total", npulse - b_np, 2);
        chk("t2_last", last_count, 2);
        stat_init = 24'h999999;

        // Simultaneous next and ok at menu_sel 3
        do_reset();
        for (int i = 0; i < 3; i++) press_next();
        b_np = npulse;
        btn_next = 1'b1; btn_ok = 1'b1;
        tick(1);
        btn_next = 1'b0; btn_ok = 1'b0;
        chk("t3_menu_hold", menu_sel, 3);
        wait_idle("t3_idle", 3000);
        chk("t3_pulses", pcnt[3], 4);
        chk("t3_total", npulse - b_np, 4);
        chk("t3_menu", menu_sel, 3);
        chk("t3_last", last_count, 4);

        // Cancel after first pulse; ok presses in cooldown are ignored
        do_reset();
        b_np = npulse; b_busy = busy_cnt;
        press_ok(c0);
        wait_pulses("t4_first", b_np, 1);
        btn_cancel = 1'b1;
        tick(1);
        btn_cancel = 1'b0;
        tick(20);
        for (int i = 0; i < 2; i++) begin
            btn_ok = 1'b1; tick(1); btn_ok = 1'b0; tick(30);
        end
        wait_idle("t4_idle", 3000);
        chk("t4_total", npulse - b_np, 1);
        chk("t4_last", last_count, 1);
        chk("t4_busy_cycles", busy_cnt - b_busy, 1002);
        tick(10);
        chk("t4_no_queue_busy", busy, 0);
        chk("t4_no_queue_pulses", npulse - b_np, 1);

        // Reset between pulses 2 and 3 with ok held across release
        do_reset();
        press_next();
        b_np = npulse;
        press_ok(c0);
        wait_pulses("t5_two", b_np, 2);
        tick(1);
        reset = 1'b1;
        btn_ok = 1'b1;
        #1;
        chk("t5_rst_pulse", care_pulse, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_last", last_count, 0);
        chk("t5_rst_menu", menu_sel, 0);
        tick(2);
        reset = 1'b0;
        tick(20);
        chk("t5_held_busy", busy, 0);
        chk("t5_held_pulses", npulse - b_np, 2);
        btn_ok = 1'b0;
        tick(5);
        chk("t5_release_busy", busy, 0);
        chk("t5_release_pulses", npulse - b_np, 2);

        chk("pulse_rules", bad, 0);
        chk("pulse_hi_bits", pcnt[6] + pcnt[7], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
